// File: rtl/cpu_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// No logic here; consumers import the package.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

package cpu_hazard_pkg;

    localparam int DEFAULT_NUM_REGS   = `NUM_REGS;
    localparam int REG_ID_W           = $clog2(DEFAULT_NUM_REGS);
    localparam int DEFAULT_MUL_STAGES = 5;

    localparam int CAUSE_LOAD   = 0;
    localparam int CAUSE_BRANCH = 1;
    localparam int CAUSE_JUMP   = 2;
    localparam int CAUSE_MUL    = 3;
    localparam int CAUSE_WAW    = 4;
    localparam int CAUSE_W      = 5;

    typedef struct packed {
        logic                write_back;
        logic [REG_ID_W-1:0] rd_id;
    } mul_writeback_t;

endpackage

// File: rtl/cpu_mul_tracker.sv
// Shift register of in-flight multiplies; an issue appears at entry 0 one cycle later.
// Never stalls: it advances every cycle, and a non-issue cycle shifts in a bubble.
module cpu_mul_tracker
    import cpu_hazard_pkg::*;
#(
    parameter int MUL_STAGES = DEFAULT_MUL_STAGES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_issue_vld,
    input  logic [REG_ID_W-1:0]            i_issue_rd,
    output logic [MUL_STAGES-1:0]          o_wb_valid,
    output logic [MUL_STAGES*REG_ID_W-1:0] o_wb_rd
);

    mul_writeback_t r_ent [MUL_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_ent[0].write_back <= i_issue_vld;
            r_ent[0].rd_id      <= i_issue_rd;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_ent[i] <= r_ent[i-1];
            end
        end
    end

    always_comb begin
        o_wb_valid = '0;
        o_wb_rd    = '0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            o_wb_valid[i]                   = r_ent[i].write_back;
            o_wb_rd[i*REG_ID_W +: REG_ID_W] = r_ent[i].rd_id;
        end
    end

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Hazard unit: combinational fetch/decode stall from stage hazards and the mul tracker.
// Zero-latency stall; cause record and saturating stall counter are registered.
module cpu_hazard_ctrl
    import cpu_hazard_pkg::*;
#(
    parameter int NUM_REGS   = `NUM_REGS,
    parameter int MUL_STAGES = DEFAULT_MUL_STAGES,
    parameter int CNT_W      = 32,
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     decode_valid,
    input  logic [RW-1:0]            decode_ra,
    input  logic [RW-1:0]            decode_rb,
    input  logic                     ra_use,
    input  logic                     rb_use,
    input  logic [RW-1:0]            decode_rd,
    input  logic                     decode_wb,
    input  logic                     decode_mul,
    input  logic                     branch_decode,
    input  logic                     jump_decode,
    input  logic                     flush,
    input  logic                     execute_mem_read,
    input  logic                     execute_wb,
    input  logic [RW-1:0]            execute_rd,
    input  logic                     commit_mem_read,
    input  logic [RW-1:0]            commit_rd,
    output logic                     stall,
    output logic [MUL_STAGES-1:0]    mul_wb_valid,
    output logic [MUL_STAGES*RW-1:0] mul_wb_rd,
    output logic [CAUSE_W-1:0]       stall_cause_q,
    output logic [CNT_W-1:0]         stall_cycles
);

    logic               w_active;
    logic               w_match_ex;
    logic               w_match_cm;
    logic               w_mul_raw;
    logic               w_mul_waw;
    logic               w_issue;
    logic [CAUSE_W-1:0] w_cause;
    logic [CAUSE_W-1:0] r_cause;
    logic [CNT_W-1:0]   r_cnt;

    function automatic logic src_match(input logic ra_u, input logic [RW-1:0] ra,
                                       input logic rb_u, input logic [RW-1:0] rb,
                                       input logic [RW-1:0] id);
        return (ra_u && (ra == id)) || (rb_u && (rb == id));
    endfunction

    assign w_active   = decode_valid && !flush;
    assign w_match_ex = src_match(ra_use, decode_ra, rb_use, decode_rb, execute_rd);
    assign w_match_cm = src_match(ra_use, decode_ra, rb_use, decode_rb, commit_rd);

    always_comb begin
        w_mul_raw = 1'b0;
        w_mul_waw = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            if (mul_wb_valid[i]) begin
                if (src_match(ra_use, decode_ra, rb_use, decode_rb, mul_wb_rd[i*RW +: RW]))
                    w_mul_raw = 1'b1;
                if (decode_wb && !decode_mul && (decode_rd == mul_wb_rd[i*RW +: RW]))
                    w_mul_waw = 1'b1;
            end
        end
    end

    always_comb begin
        w_cause               = '0;
        w_cause[CAUSE_LOAD]   = w_active && ((execute_mem_read && w_match_ex) ||
                                             (commit_mem_read && w_match_cm));
        w_cause[CAUSE_BRANCH] = w_active && branch_decode && execute_wb && w_match_ex;
        w_cause[CAUSE_JUMP]   = w_active && jump_decode && execute_wb && ra_use &&
                                (decode_ra == execute_rd);
        w_cause[CAUSE_MUL]    = w_active && w_mul_raw;
        w_cause[CAUSE_WAW]    = w_active && w_mul_waw;
    end

    assign stall   = |w_cause;
    // A stalled or flushed mul must not enter the tracker, or it would be counted twice.
    assign w_issue = w_active && decode_mul && decode_wb && !stall;

    cpu_mul_tracker #(
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_tracker (
        .clk         (clk),
        .reset       (reset),
        .i_issue_vld (w_issue),
        .i_issue_rd  (decode_rd),
        .o_wb_valid  (mul_wb_valid),
        .o_wb_rd     (mul_wb_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause <= '0;
            r_cnt   <= '0;
        end else begin
            r_cause <= w_cause;
            if (stall && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stall_cause_q = r_cause;
    assign stall_cycles  = r_cnt;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl with hand-computed expectations (CNT_W=4).
module tb_cpu_hazard_ctrl;

    localparam int RW = 5;
    localparam int MS = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          decode_valid, ra_use, rb_use, decode_wb, decode_mul;
    logic          branch_decode, jump_decode, flush;
    logic          execute_mem_read, execute_wb, commit_mem_read;
    logic [RW-1:0] decode_ra, decode_rb, decode_rd, execute_rd, commit_rd;
    logic          stall;
    logic [MS-1:0] mul_wb_valid;
    logic [MS*RW-1:0] mul_wb_rd;
    logic [4:0]    stall_cause_q;
    logic [CW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    cpu_hazard_ctrl #(.NUM_REGS(32), .MUL_STAGES(MS), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .decode_valid     (decode_valid),
        .decode_ra        (decode_ra),
        .decode_rb        (decode_rb),
        .ra_use           (ra_use),
        .rb_use           (rb_use),
        .decode_rd        (decode_rd),
        .decode_wb        (decode_wb),
        .decode_mul       (decode_mul),
        .branch_decode    (branch_decode),
        .jump_decode      (jump_decode),
        .flush            (flush),
        .execute_mem_read (execute_mem_read),
        .execute_wb       (execute_wb),
        .execute_rd       (execute_rd),
        .commit_mem_read  (commit_mem_read),
        .commit_rd        (commit_rd),
        .stall            (stall),
        .mul_wb_valid     (mul_wb_valid),
        .mul_wb_rd        (mul_wb_rd),
        .stall_cause_q    (stall_cause_q),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        decode_valid = 0; ra_use = 0; rb_use = 0; decode_wb = 0; decode_mul = 0;
        branch_decode = 0; jump_decode = 0; flush = 0;
        execute_mem_read = 0; execute_wb = 0; commit_mem_read = 0;
        decode_ra = 0; decode_rb = 0; decode_rd = 0; execute_rd = 0; commit_rd = 0;
    endtask

    task automatic load_hazard();
        decode_valid = 1; execute_mem_read = 1; execute_rd = 5; ra_use = 1; decode_ra = 5;
    endtask

    task automatic issue_mul(input logic [RW-1:0] rd);
        decode_valid = 1; decode_mul = 1; decode_wb = 1; decode_rd = rd;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        chk("reset_valid", 32'(mul_wb_valid), 0);
        chk("reset_rd", 32'(mul_wb_rd), 0);
        chk("reset_cause", 32'(stall_cause_q), 0);
        chk("reset_cycles", 32'(stall_cycles), 0);
        chk("reset_stall", 32'(stall), 0);
        reset = 0;
        tick();

        // load-use via execute, then with the source unused, then via commit
        load_hazard(); #1;
        chk("load_ex_stall", 32'(stall), 1);
        tick();
        chk("load_cause", 32'(stall_cause_q), 32'b00001);
        chk("load_cycles", 32'(stall_cycles), 1);
        ra_use = 0; #1;
        chk("load_nouse_stall", 32'(stall), 0);
        tick();
        chk("load_nouse_cause", 32'(stall_cause_q), 0);
        idle(); decode_valid = 1; commit_mem_read = 1; commit_rd = 6; rb_use = 1; decode_rb = 6; #1;
        chk("load_cm_stall", 32'(stall), 1);
        tick();
        chk("load_cm_cycles", 32'(stall_cycles), 2);

        // branch on rb, jump only looks at ra
        idle(); decode_valid = 1; branch_decode = 1; execute_wb = 1; execute_rd = 3;
        rb_use = 1; decode_rb = 3; #1;
        chk("branch_stall", 32'(stall), 1);
        tick();
        chk("branch_cause", 32'(stall_cause_q), 32'b00010);
        branch_decode = 0; jump_decode = 1; #1;
        chk("jump_rb_stall", 32'(stall), 0);
        ra_use = 1; decode_ra = 3; #1;
        chk("jump_ra_stall", 32'(stall), 1);
        tick();
        chk("jump_cause", 32'(stall_cause_q), 32'b00100);
        chk("jump_cycles", 32'(stall_cycles), 4);

        // flush masks a hazard
        idle(); load_hazard(); flush = 1; #1;
        chk("flush_stall", 32'(stall), 0);
        tick();
        chk("flush_cause", 32'(stall_cause_q), 0);
        chk("flush_cycles", 32'(stall_cycles), 4);

        // mul RAW on r7 through every tracker stage
        idle(); issue_mul(7); #1;
        chk("mul_issue_stall", 32'(stall), 0);
        tick();
        chk("mul_rd0", 32'(mul_wb_rd[RW-1:0]), 7);
        idle(); decode_valid = 1; ra_use = 1; decode_ra = 7;
        for (int k = 0; k < MS; k++) begin
            #1;
            chk($sformatf("mul_raw_stall_%0d", k), 32'(stall), 1);
            chk($sformatf("mul_raw_valid_%0d", k), 32'(mul_wb_valid), 32'(1) << k);
            tick();
        end
        chk("mul_gone_valid", 32'(mul_wb_valid), 0);
        chk("mul_gone_stall", 32'(stall), 0);
        chk("mul_raw_cause", 32'(stall_cause_q), 32'b01000);
        chk("mul_raw_cycles", 32'(stall_cycles), 9);

        // WAW against in-flight mul r9; a mul to r9 is allowed
        idle(); issue_mul(9);
        tick();
        idle(); decode_valid = 1; decode_wb = 1; decode_rd = 9; #1;
        chk("waw_stall", 32'(stall), 1);
        tick();
        chk("waw_cause", 32'(stall_cause_q), 32'b10000);
        chk("waw_valid", 32'(mul_wb_valid), 32'b00010);
        chk("waw_rd1", 32'(mul_wb_rd[2*RW-1:RW]), 9);
        decode_mul = 1; #1;
        chk("waw_mul_stall", 32'(stall), 0);
        tick();
        chk("waw_mul_valid", 32'(mul_wb_valid), 32'b00101);
        chk("waw_cycles", 32'(stall_cycles), 10);

        // stalled or flushed mul is not inserted
        idle(); issue_mul(12); execute_mem_read = 1; execute_rd = 5; ra_use = 1; decode_ra = 5; #1;
        chk("ins_stall", 32'(stall), 1);
        tick();
        chk("ins_stall_valid", 32'(mul_wb_valid), 32'b01010);
        idle(); issue_mul(12); flush = 1; #1;
        chk("ins_flush_stall", 32'(stall), 0);
        tick();
        chk("ins_flush_valid", 32'(mul_wb_valid), 32'b10100);
        idle();
        for (int k = 0; k < MS; k++) tick();
        chk("drain_valid", 32'(mul_wb_valid), 0);

        // counter saturation: from 11, stall 2^CW+3 cycles
        load_hazard();
        tick(); tick();
        chk("cnt_13", 32'(stall_cycles), 13);
        for (int k = 0; k < (1 << CW) + 1; k++) tick();
        chk("cnt_sat", 32'(stall_cycles), 15);

        // reset mid-operation with a mul in flight
        idle(); issue_mul(4);
        tick();
        idle(); load_hazard();
        tick();
        idle(); reset = 1;
        tick();
        chk("rst_valid", 32'(mul_wb_valid), 0);
        chk("rst_rd", 32'(mul_wb_rd), 0);
        chk("rst_cause", 32'(stall_cause_q), 0);
        chk("rst_cycles", 32'(stall_cycles), 0);
        chk("rst_stall", 32'(stall), 0);
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
